// File: rtl/int_sched_if.sv
// Request/issue bundle for int_sched: two requesters on one side, the shared
// intcalc unit on the other. The slave modport is the scheduler's view.
interface int_sched_if #(
  parameter int WIDTH = 32
);
  logic [1:0]         req_i;
  logic [7:0]         func_i;
  logic [2*WIDTH-1:0] in1_i;
  logic [2*WIDTH-1:0] in2_i;
  logic [1:0]         flush_i;
  logic [1:0]         gnt_o;
  logic [1:0]         done_o;
  logic [WIDTH-1:0]   result_o;
  logic               busy_o;
  logic [3:0]         int_func_o;
  logic [WIDTH-1:0]   int_in1_o;
  logic [WIDTH-1:0]   int_in2_o;
  logic [WIDTH-1:0]   int_out_i;

  modport slave (
    input  req_i, func_i, in1_i, in2_i, flush_i, int_out_i,
    output gnt_o, done_o, result_o, busy_o, int_func_o, int_in1_o, int_in2_o
  );

  modport master (
    output req_i, func_i, in1_i, in2_i, flush_i, int_out_i,
    input  gnt_o, done_o, result_o, busy_o, int_func_o, int_in1_o, int_in2_o
  );
endinterface

// File: rtl/int_sched.sv
// Two-requester sequencer for the shared multi-cycle intcalc unit.
// Define INT_SCHED_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
//
// Handshake: req_i[r] is a level; the requester holds it with stable func/operands
// until gnt_o[r] is seen high in a cycle (that cycle is the accept). Completion is
// a single-cycle done_o[owner] pulse with result_o valid alongside; there is no
// backpressure on completion. flush_i[r] cancels r's in-flight op or blocks its grant.
module int_sched #(
  parameter int LATENCY = 4,
  parameter int WIDTH   = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  int_sched_if.slave  bus,
  output logic        dbg_state_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic [1:0]       done_q, done_d;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       func_q;
  logic [WIDTH-1:0] in1_q, in2_q;

  logic [1:0]       eff_req;
  logic             win;
  logic [1:0]       gnt;
  logic             load;
  logic             capture;

  // A requester flushing in the same cycle it requests is not eligible.
  assign eff_req = bus.req_i & ~bus.flush_i;

`ifdef INT_SCHED_RR_EN
  logic last_q;

  always_comb begin
    win = ~eff_req[0];
    if (eff_req == 2'b11) win = ~last_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_q <= 1'b1;
    end else if (load) begin
      last_q <= win;
    end
  end
`else
  assign win = ~eff_req[0];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    done_d  = 2'b00;
    gnt     = 2'b00;
    load    = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (|eff_req) begin
          gnt[win] = 1'b1;
          load     = 1'b1;
          owner_d  = win;
          cnt_d    = CNT_INIT;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // Owner flush takes precedence over a completion in the same cycle.
        if (bus.flush_i[owner_q]) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          capture         = 1'b1;
          done_d[owner_q] = 1'b1;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      owner_q  <= 1'b0;
      done_q   <= 2'b00;
      result_q <= '0;
      func_q   <= 4'd0;
      in1_q    <= '0;
      in2_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      done_q  <= done_d;
      if (capture) result_q <= bus.int_out_i;
      if (load) begin
        func_q <= win ? bus.func_i[7:4] : bus.func_i[3:0];
        in1_q  <= win ? bus.in1_i[2*WIDTH-1:WIDTH] : bus.in1_i[WIDTH-1:0];
        in2_q  <= win ? bus.in2_i[2*WIDTH-1:WIDTH] : bus.in2_i[WIDTH-1:0];
      end
    end
  end

  assign bus.gnt_o      = gnt;
  assign bus.done_o     = done_q;
  assign bus.result_o   = result_q;
  assign bus.busy_o     = (state_q == BUSY);
  assign bus.int_func_o = func_q;
  assign bus.int_in1_o  = in1_q;
  assign bus.int_in2_o  = in2_q;
  assign dbg_state_o    = state_q;

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_i) $onehot0(bus.gnt_o));
  a_done_onehot: assert property (@(posedge clk_i) disable iff (!rst_i) $onehot0(bus.done_o));
  // Operands presented to intcalc must not move while it is computing.
  a_ops_stable: assert property (@(posedge clk_i) disable iff (!rst_i)
    (state_q == BUSY) |=> ($stable(func_q) && $stable(in1_q) && $stable(in2_q)));

endmodule

// File: tb/tb_int_sched.sv
// Self-checking bench for int_sched: directed scenarios followed by a randomized
// run against a transaction-level model of grants, completions and flushes.
module tb_int_sched;
  localparam int W   = 32;
  localparam int LAT = 4;

  localparam logic [3:0] F_ADD = 4'd0;
  localparam logic [3:0] F_SUB = 4'd1;
  localparam logic [3:0] F_MUL = 4'd2;
  localparam logic [3:0] F_DIV = 4'd3;

  logic clk = 1'b0;
  logic rst_i;
  logic dbg_state;
  int   checks = 0;
  int   errors = 0;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic         exp_own_q[$];

  always #5 clk = ~clk;

  int_sched_if #(.WIDTH(W)) bus ();

  int_sched #(.LATENCY(LAT), .WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Behavioural intcalc: the bench's stand-in for the shared unit.
  function automatic logic [W-1:0] calc(input logic [3:0] f, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    case (f)
      F_ADD:   return a + b;
      F_SUB:   return a - b;
      F_MUL:   return a * b;
      F_DIV:   return (b == '0) ? '1 : a / b;
      default: return a ^ b;
    endcase
  endfunction

  assign bus.int_out_i = calc(bus.int_func_o, bus.int_in1_o, bus.int_in2_o);

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_i   = 2'b00;
    bus.flush_i = 2'b00;
  endtask

  task automatic set_op(input int r, input logic [3:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    bus.func_i[4*r +: 4] = f;
    bus.in1_i[W*r +: W]  = a;
    bus.in2_i[W*r +: W]  = b;
    bus.req_i[r]         = 1'b1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    idle_inputs();
    repeat (2) step();
    rst_i = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_i = 1'b0;
    idle_inputs();
    bus.func_i = '0;
    bus.in1_i  = '0;
    bus.in2_i  = '0;
    repeat (2) step();
    checks++;
    if ({bus.gnt_o, bus.done_o, bus.busy_o, dbg_state} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got gnt=%b done=%b busy=%b st=%b exp all 0",
               bus.gnt_o, bus.done_o, bus.busy_o, dbg_state);
    end
    checks++;
    if (bus.result_o !== '0) begin
      errors++; $display("FAIL reset_result got %0h exp 0", bus.result_o);
    end
    checks++;
    if ({bus.int_func_o, bus.int_in1_o, bus.int_in2_o} !== '0) begin
      errors++;
      $display("FAIL reset_int got f=%0h a=%0h b=%0h exp 0",
               bus.int_func_o, bus.int_in1_o, bus.int_in2_o);
    end
    rst_i = 1'b1;
  endtask

  task automatic test_single();
    step();
    set_op(0, F_MUL, 6, 7);
    #1;
    checks++;
    if (bus.gnt_o !== 2'b01) begin
      errors++; $display("FAIL single_gnt got %b exp 01", bus.gnt_o);
    end
    for (int k = 1; k <= LAT; k++) begin
      step();
      if (k == 1) idle_inputs();
      checks++;
      if (bus.busy_o !== 1'b1 || bus.done_o !== 2'b00 || bus.int_in1_o !== 32'd6 ||
          bus.int_func_o !== F_MUL) begin
        errors++;
        $display("FAIL single_busy k=%0d got busy=%b done=%b in1=%0d f=%0d exp 1 00 6 2",
                 k, bus.busy_o, bus.done_o, bus.int_in1_o, bus.int_func_o);
      end
    end
    step();
    checks++;
    if (bus.done_o !== 2'b01 || bus.result_o !== 32'd42 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL single_done got done=%b res=%0d busy=%b exp 01 42 0",
               bus.done_o, bus.result_o, bus.busy_o);
    end
    step();
    checks++;
    if (bus.done_o !== 2'b00 || bus.result_o !== 32'd42) begin
      errors++;
      $display("FAIL single_pulse got done=%b res=%0d exp 00 42", bus.done_o, bus.result_o);
    end
  endtask

  task automatic test_tie();
    logic [1:0] exp_g [3];
`ifdef INT_SCHED_RR_EN
    exp_g = '{2'b01, 2'b10, 2'b01};
`else
    exp_g = '{2'b01, 2'b01, 2'b01};
`endif
    do_reset();
    step();
    set_op(0, F_ADD, 1, 2);
    set_op(1, F_SUB, 10, 3);
    #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (bus.gnt_o !== exp_g[g]) begin
        errors++; $display("FAIL tie_gnt%0d got %b exp %b", g, bus.gnt_o, exp_g[g]);
      end
      step();
      checks++;
      if (bus.gnt_o !== 2'b00) begin
        errors++; $display("FAIL tie_hold%0d got %b exp 00", g, bus.gnt_o);
      end
      repeat (LAT) step();
      checks++;
      if (bus.done_o !== exp_g[g] ||
          bus.result_o !== ((exp_g[g] == 2'b01) ? 32'd3 : 32'd7)) begin
        errors++;
        $display("FAIL tie_done%0d got done=%b res=%0d exp %b %0d", g, bus.done_o,
                 bus.result_o, exp_g[g], (exp_g[g] == 2'b01) ? 3 : 7);
      end
    end
    idle_inputs();
    repeat (LAT + 2) step();
  endtask

  task automatic test_flush();
    step();
    set_op(0, F_ADD, 5, 6);
    #1;
    step();
    idle_inputs();
    repeat (LAT) step();
    checks++;
    if (bus.done_o !== 2'b01 || bus.result_o !== 32'd11) begin
      errors++;
      $display("FAIL flush_base got done=%b res=%0d exp 01 11", bus.done_o, bus.result_o);
    end
    set_op(0, F_MUL, 9, 9);
    #1;
    checks++;
    if (bus.gnt_o !== 2'b01) begin
      errors++; $display("FAIL flush_gnt0 got %b exp 01", bus.gnt_o);
    end
    step();
    bus.req_i[0] = 1'b0;
    set_op(1, F_SUB, 50, 8);
    #1;
    checks++;
    if (bus.gnt_o !== 2'b00) begin
      errors++; $display("FAIL flush_pending got %b exp 00", bus.gnt_o);
    end
    step();
    bus.flush_i = 2'b01;
    step();
    bus.flush_i = 2'b00;
    #1;
    checks++;
    if (bus.done_o !== 2'b00 || bus.result_o !== 32'd11 || bus.busy_o !== 1'b0 ||
        bus.gnt_o !== 2'b10) begin
      errors++;
      $display("FAIL flush_abort got done=%b res=%0d busy=%b gnt=%b exp 00 11 0 10",
               bus.done_o, bus.result_o, bus.busy_o, bus.gnt_o);
    end
    step();
    idle_inputs();
    for (int k = 1; k < LAT; k++) begin
      step();
      checks++;
      if (bus.done_o !== 2'b00 || bus.result_o !== 32'd11) begin
        errors++;
        $display("FAIL flush_nodone k=%0d got done=%b res=%0d exp 00 11",
                 k, bus.done_o, bus.result_o);
      end
    end
    step();
    checks++;
    if (bus.done_o !== 2'b10 || bus.result_o !== 32'd42) begin
      errors++;
      $display("FAIL flush_req1 got done=%b res=%0d exp 10 42", bus.done_o, bus.result_o);
    end
  endtask

  task automatic test_flush_cnt0();
    step();
    set_op(0, F_MUL, 3, 4);
    #1;
    step();
    idle_inputs();
    repeat (LAT - 1) step();
    bus.flush_i = 2'b01;
    step();
    bus.flush_i = 2'b00;
    checks++;
    if (bus.done_o !== 2'b00 || bus.result_o !== 32'd42 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_cnt0 got done=%b res=%0d busy=%b exp 00 42 0",
               bus.done_o, bus.result_o, bus.busy_o);
    end
    set_op(1, F_ADD, 7, 8);
    #1;
    checks++;
    if (bus.gnt_o !== 2'b10) begin
      errors++; $display("FAIL nonown_gnt got %b exp 10", bus.gnt_o);
    end
    step();
    idle_inputs();
    step();
    bus.flush_i = 2'b01;
    step();
    bus.flush_i = 2'b00;
    repeat (LAT - 2) step();
    checks++;
    if (bus.done_o !== 2'b10 || bus.result_o !== 32'd15) begin
      errors++;
      $display("FAIL nonown_done got done=%b res=%0d exp 10 15", bus.done_o, bus.result_o);
    end
  endtask

  task automatic test_flush_idle();
    step();
    bus.flush_i = 2'b01;
    set_op(0, F_ADD, 2, 2);
    #1;
    checks++;
    if (bus.gnt_o !== 2'b00) begin
      errors++; $display("FAIL fidle_block got %b exp 00", bus.gnt_o);
    end
    set_op(1, F_ADD, 3, 3);
    #1;
    checks++;
    if (bus.gnt_o !== 2'b10) begin
      errors++; $display("FAIL fidle_other got %b exp 10", bus.gnt_o);
    end
    step();
    idle_inputs();
    repeat (LAT) step();
    checks++;
    if (bus.done_o !== 2'b10 || bus.result_o !== 32'd6) begin
      errors++;
      $display("FAIL fidle_done got done=%b res=%0d exp 10 6", bus.done_o, bus.result_o);
    end
  endtask

  task automatic test_stability();
    step();
    set_op(0, F_SUB, 1000, 234);
    #1;
    for (int k = 1; k <= LAT; k++) begin
      step();
      if (k == 1) idle_inputs();
      bus.func_i = 8'($urandom);
      bus.in1_i  = {$urandom, $urandom};
      bus.in2_i  = {$urandom, $urandom};
      #1;
      checks++;
      if (bus.int_in1_o !== 32'd1000 || bus.int_in2_o !== 32'd234 ||
          bus.int_func_o !== F_SUB) begin
        errors++;
        $display("FAIL stable_ops k=%0d got f=%0d a=%0d b=%0d exp 1 1000 234",
                 k, bus.int_func_o, bus.int_in1_o, bus.int_in2_o);
      end
    end
    step();
    checks++;
    if (bus.done_o !== 2'b01 || bus.result_o !== 32'd766) begin
      errors++;
      $display("FAIL stable_done got done=%b res=%0d exp 01 766", bus.done_o, bus.result_o);
    end
  endtask

  task automatic test_reset_mid();
    step();
    set_op(0, F_ADD, 1, 1);
    #1;
    step();
    idle_inputs();
    step();
    #3;
    rst_i = 1'b0;
    #1;
    checks++;
    if ({bus.gnt_o, bus.done_o, bus.busy_o, dbg_state} !== 6'b0 || bus.result_o !== '0 ||
        {bus.int_func_o, bus.int_in1_o, bus.int_in2_o} !== '0) begin
      errors++;
      $display("FAIL rstmid_zero got gnt=%b done=%b busy=%b st=%b res=%0h a=%0h exp all 0",
               bus.gnt_o, bus.done_o, bus.busy_o, dbg_state, bus.result_o, bus.int_in1_o);
    end
    repeat (2) step();
    rst_i = 1'b1;
    step();
    checks++;
    if (bus.done_o !== 2'b00 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_abort got done=%b busy=%b exp 00 0", bus.done_o, bus.busy_o);
    end
    set_op(1, F_DIV, 100, 3);
    #1;
    checks++;
    if (bus.gnt_o !== 2'b10) begin
      errors++; $display("FAIL rstmid_gnt got %b exp 10", bus.gnt_o);
    end
    step();
    idle_inputs();
    repeat (LAT) step();
    checks++;
    if (bus.done_o !== 2'b10 || bus.result_o !== 32'd33) begin
      errors++;
      $display("FAIL rstmid_div got done=%b res=%0d exp 10 33", bus.done_o, bus.result_o);
    end
  endtask

  // Transaction model: an op granted in cycle c completes in c+LAT+1 unless its
  // owner flushes while it is in flight; nothing is granted until it is gone.
  task automatic test_random();
    logic [1:0]   want, fl, elig, exp_gnt, exp_done;
    logic [3:0]   f [2];
    logic [W-1:0] a [2];
    logic [W-1:0] b [2];
    logic [3:0]   lf;
    logic [W-1:0] la, lb, res_m;
    logic         own_m, win;
    int           free_at, last_g;
    do_reset();
    exp_q.delete();
    exp_cyc_q.delete();
    exp_own_q.delete();
    want = 2'b00; free_at = 0; last_g = 1; own_m = 1'b0;
    lf = '0; la = '0; lb = '0; res_m = '0;
    for (int r = 0; r < 2; r++) begin
      f[r] = '0; a[r] = '0; b[r] = '0;
    end
    for (int c = 0; c < 800; c++) begin
      step();
      exp_done = 2'b00;
      if (exp_q.size() > 0 && exp_cyc_q[0] == c) begin
        exp_done[exp_own_q[0]] = 1'b1;
        res_m = exp_q.pop_front();
        void'(exp_cyc_q.pop_front());
        void'(exp_own_q.pop_front());
      end
      checks++;
      if (bus.done_o !== exp_done) begin
        errors++; $display("FAIL rnd_done c=%0d got %b exp %b", c, bus.done_o, exp_done);
      end
      checks++;
      if (bus.result_o !== res_m) begin
        errors++; $display("FAIL rnd_result c=%0d got %0h exp %0h", c, bus.result_o, res_m);
      end
      checks++;
      if (bus.busy_o !== (c < free_at)) begin
        errors++; $display("FAIL rnd_busy c=%0d got %b exp %b", c, bus.busy_o, c < free_at);
      end
      checks++;
      if ({bus.int_func_o, bus.int_in1_o, bus.int_in2_o} !== {lf, la, lb}) begin
        errors++;
        $display("FAIL rnd_int c=%0d got %0h/%0h/%0h exp %0h/%0h/%0h", c, bus.int_func_o,
                 bus.int_in1_o, bus.int_in2_o, lf, la, lb);
      end
      for (int r = 0; r < 2; r++) begin
        if (!want[r]) begin
          f[r] = 4'($urandom_range(0, 4));
          a[r] = $urandom;
          b[r] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 9)) : $urandom;
          if ($urandom_range(0, 3) == 0) want[r] = 1'b1;
        end
        fl[r] = ($urandom_range(0, 9) == 0);
      end
      bus.req_i   = want;
      bus.flush_i = fl;
      bus.func_i  = {f[1], f[0]};
      bus.in1_i   = {a[1], a[0]};
      bus.in2_i   = {b[1], b[0]};
      #1;
      exp_gnt = 2'b00;
      if (c < free_at) begin
        if (fl[own_m]) begin
          free_at = c + 1;
          void'(exp_q.pop_back());
          void'(exp_cyc_q.pop_back());
          void'(exp_own_q.pop_back());
        end
      end else begin
        elig = want & ~fl;
        if (elig != 2'b00) begin
`ifdef INT_SCHED_RR_EN
          if (elig == 2'b11) win = (last_g == 0);
          else win = ~elig[0];
          last_g = int'(win);
`else
          win = ~elig[0];
`endif
          exp_gnt[win] = 1'b1;
          own_m = win;
          free_at = c + LAT + 1;
          exp_q.push_back(calc(f[win], a[win], b[win]));
          exp_cyc_q.push_back(c + LAT + 1);
          exp_own_q.push_back(win);
          lf = f[win]; la = a[win]; lb = b[win];
          want[win] = 1'b0;
        end
      end
      checks++;
      if (bus.gnt_o !== exp_gnt) begin
        errors++; $display("FAIL rnd_gnt c=%0d got %b exp %b", c, bus.gnt_o, exp_gnt);
      end
    end
    idle_inputs();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_flush();
    test_flush_cnt0();
    test_flush_idle();
    test_stability();
    test_reset_mid();
    test_random();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
